temp_monitor: RTL

//  Parametrised multi-sensor temperature sampler; successor to the single-sensor, free-running i2c_master path.

---
 rtl/temp_mon_pkg.sv | 27 ++
 rtl/temp_mon_if.sv | 22 ++
 rtl/temp_ch_stats.sv | 79 +++++++
 rtl/temp_monitor.sv | 128 ++++++++++++
 4 files changed

// File: rtl/temp_mon_pkg.sv
// Shared types and helpers for the multi-channel temperature monitor.
package temp_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_REQ,
        ST_RSP,
        ST_UPDATE
    } state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Most positive two's complement value of width w, zero-extended to 64 bits.
    function automatic logic [63:0] smax_bits(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of width w, as a raw bit pattern.
    function automatic logic [63:0] smin_bits(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/temp_mon_if.sv
// Request/response link between the monitor and the I2C front end.
interface temp_mon_if #(
    parameter int unsigned CH_W   = 1,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic [CH_W-1:0]   req_ch;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_ch,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_ch,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/temp_ch_stats.sv
// Per-channel statistics: block average, running min/max, hysteresis alarm.
module temp_ch_stats
    import temp_mon_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int          ALARM_HI   = 50,
    parameter int          ALARM_HYST = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_minmax,
    input  logic                     smp_valid,
    input  logic signed [DATA_W-1:0] smp_data,
    output logic signed [DATA_W-1:0] avg,
    output logic                     avg_valid,
    output logic signed [DATA_W-1:0] min_val,
    output logic signed [DATA_W-1:0] max_val,
    output logic                     alarm
);
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam logic signed [DATA_W-1:0] SMAX = DATA_W'(smax_bits(DATA_W));
    localparam logic signed [DATA_W-1:0] SMIN = DATA_W'(smin_bits(DATA_W));

    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;
    logic signed [ACC_W-1:0]  acc_sum_c;
    logic signed [DATA_W-1:0] avg_new_c;
    logic                     block_done_c;

    assign acc_sum_c    = acc + ACC_W'(smp_data);
    assign avg_new_c    = DATA_W'(acc_sum_c >>> AVG_LOG2);
    assign block_done_c = (cnt == CNT_W'((1 << AVG_LOG2) - 1));

    // Accumulate samples; on a full block publish the floor average and re-evaluate the alarm.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (smp_valid) begin
                if (block_done_c) begin
                    acc       <= '0;
                    cnt       <= '0;
                    avg       <= avg_new_c;
                    avg_valid <= 1'b1;
                    if (int'(avg_new_c) >= ALARM_HI) begin
                        alarm <= 1'b1;
                    end else if (int'(avg_new_c) < ALARM_HI - ALARM_HYST) begin
                        alarm <= 1'b0;
                    end
                end else begin
                    acc <= acc_sum_c;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Running extremes; a clear coinciding with a sample restarts from that sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_val <= SMAX;
            max_val <= SMIN;
        end else if (clr_minmax) begin
            min_val <= smp_valid ? smp_data : SMAX;
            max_val <= smp_valid ? smp_data : SMIN;
        end else if (smp_valid) begin
            if (smp_data < min_val) min_val <= smp_data;
            if (smp_data > max_val) max_val <= smp_data;
        end
    end

endmodule

// File: rtl/temp_monitor.sv
// Round-robin multi-sensor sampler: tick timing, request FSM, response capture.
module temp_monitor
    import temp_mon_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter int unsigned TIMEOUT    = 200000,
    parameter int          ALARM_HI   = 50,
    parameter int          ALARM_HYST = 2
) (
    input  logic                     clk_100MHz,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clr_minmax,
    temp_mon_if.master               fe,
    output logic [NUM_CH*DATA_W-1:0] avg_data,
    output logic [NUM_CH-1:0]        avg_valid,
    output logic [NUM_CH*DATA_W-1:0] min_data,
    output logic [NUM_CH*DATA_W-1:0] max_data,
    output logic [NUM_CH-1:0]        alarm,
    output logic                     err_pulse,
    output logic                     overrun
);
    localparam int unsigned CH_W   = clog2_min1(NUM_CH);
    localparam int unsigned TICK_W = clog2_min1(SAMPLE_DIV);
    localparam int unsigned TO_W   = clog2_min1(TIMEOUT);

    state_t                    state, state_next;
    logic [TICK_W-1:0]         tick_cnt;
    logic [TO_W-1:0]           to_cnt;
    logic [CH_W-1:0]           ch;
    logic                      req_valid_q;
    logic                      smp_valid;
    logic signed [DATA_W-1:0]  smp_data;
    logic [CH_W-1:0]           smp_ch;
    logic                      tick_c;
    logic                      rsp_hit_c;
    logic                      timeout_c;

    assign fe.req_valid = req_valid_q;
    assign fe.req_ch    = ch;
    assign tick_c       = enable && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
    assign rsp_hit_c    = (state == ST_RSP) && fe.rsp_valid;
    assign timeout_c    = (state == ST_RSP) && !fe.rsp_valid && (to_cnt == TO_W'(TIMEOUT - 1));

    // Sample-interval counter, parked at zero while disabled.
    always_ff @(posedge clk_100MHz) begin
        if (rst || !enable || tick_c) tick_cnt <= '0;
        else                          tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk_100MHz) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next-state: an accepted request always runs to UPDATE before enable is honoured.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:      if (enable) state_next = ST_WAIT_TICK;
            ST_WAIT_TICK: begin
                if (!enable)     state_next = ST_IDLE;
                else if (tick_c) state_next = ST_REQ;
            end
            ST_REQ:       if (req_valid_q && fe.req_ready) state_next = ST_RSP;
            ST_RSP:       if (fe.rsp_valid || timeout_c) state_next = ST_UPDATE;
            ST_UPDATE:    state_next = ST_WAIT_TICK;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Request strobe, response timeout, channel pointer and error/overrun flags.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            to_cnt      <= '0;
            ch          <= '0;
            err_pulse   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            req_valid_q <= (state_next == ST_REQ);
            to_cnt      <= (state == ST_RSP) ? to_cnt + TO_W'(1) : '0;
            err_pulse   <= (rsp_hit_c && fe.rsp_err) || timeout_c;
            if (state == ST_UPDATE) begin
                ch <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
            end
            if (tick_c && (state != ST_WAIT_TICK)) overrun <= 1'b1;
        end
    end

    // Register a good response together with the channel it belongs to.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_ch    <= '0;
        end else begin
            smp_valid <= rsp_hit_c && !fe.rsp_err;
            smp_data  <= fe.rsp_data;
            smp_ch    <= ch;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        temp_ch_stats #(
            .DATA_W     (DATA_W),
            .AVG_LOG2   (AVG_LOG2),
            .ALARM_HI   (ALARM_HI),
            .ALARM_HYST (ALARM_HYST)
        ) u_stats (
            .clk        (clk_100MHz),
            .rst        (rst),
            .clr_minmax (clr_minmax),
            .smp_valid  (smp_valid && (smp_ch == CH_W'(i))),
            .smp_data   (smp_data),
            .avg        (avg_data[i*DATA_W +: DATA_W]),
            .avg_valid  (avg_valid[i]),
            .min_val    (min_data[i*DATA_W +: DATA_W]),
            .max_val    (max_data[i*DATA_W +: DATA_W]),
            .alarm      (alarm[i])
        );
    end

endmodule
